// File: rtl/uart_tx_sched_pkg.sv
// Shared constants and state encoding for the two-requester UART transmit scheduler.
package uart_tx_sched_pkg;

  localparam int unsigned TIMEOUT_W_DEF = 16;
  localparam int unsigned MAX_BYTES_DEF = 32;
  localparam int unsigned BCNT_W        = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    SEND    = 2'd2,
    RELEASE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Grants the UART transmit buffer to one of two byte-stream requesters and paces
// bytes out on the baud strobe, with per-grant byte cap and stall timeout.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = TIMEOUT_W_DEF,
  parameter int unsigned MAX_BYTES = MAX_BYTES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] rq_req,
  input  logic [7:0] rq_data0,
  input  logic [7:0] rq_data1,
  input  logic [1:0] rq_last,
  output logic [1:0] rq_ack,
  output logic [1:0] grant,
  input  logic       tx_ready,
  input  logic       baud_x1,
  output logic [7:0] tx_data,
  output logic       tx_strobe,
  output logic       busy,
  output logic       timeout_err
);

  tx_state_e            state;
  logic                 owner;
  logic                 rr_last;
  logic [BCNT_W-1:0]    byte_cnt;
  logic [TIMEOUT_W-1:0] stall_cnt;
  logic [1:0]           win;

  logic                 own_req;
  logic                 own_last;
  logic [7:0]           own_data;
  logic [BCNT_W:0]      cnt_inc;
  logic                 end_of_grant;
  logic [TIMEOUT_W-1:0] stall_inc;

  rr_arb2 u_arb (
    .req  (rq_req),
    .last (rr_last),
    .win  (win)
  );

  assign own_req      = rq_req[owner];
  assign own_last     = rq_last[owner];
  assign own_data     = owner ? rq_data1 : rq_data0;
  assign cnt_inc      = {1'b0, byte_cnt} + (BCNT_W + 1)'(1);
  assign end_of_grant = own_last || (cnt_inc >= (BCNT_W + 1)'(MAX_BYTES));
  assign stall_inc    = stall_cnt + TIMEOUT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      rr_last     <= 1'b1;
      byte_cnt    <= '0;
      stall_cnt   <= '0;
      grant       <= 2'b00;
      rq_ack      <= 2'b00;
      tx_data     <= 8'h00;
      tx_strobe   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rq_ack      <= 2'b00;
      tx_strobe   <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rq_req != 2'b00) begin
            grant <= win;
            owner <= win[1];
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          byte_cnt  <= '0;
          stall_cnt <= '0;
          state     <= SEND;
        end
        SEND: begin
          // A dropped request aborts even when a byte could have gone out this cycle.
          if (!own_req) begin
            grant <= 2'b00;
            state <= RELEASE;
          end else if (baud_x1 && tx_ready) begin
            tx_strobe <= 1'b1;
            rq_ack    <= owner ? 2'b10 : 2'b01;
            tx_data   <= own_data;
            stall_cnt <= '0;
            if (byte_cnt != '1) begin
              byte_cnt <= BCNT_W'(cnt_inc);
            end
            if (end_of_grant) begin
              grant <= 2'b00;
              state <= RELEASE;
            end
          end else if (!tx_ready) begin
            stall_cnt <= stall_inc;
            if (stall_inc == '1) begin
              timeout_err <= 1'b1;
              grant       <= 2'b00;
              state       <= RELEASE;
            end
          end
        end
        RELEASE: begin
          rr_last <= owner;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed vector table, corner sequences and
// a randomized run checked by a transaction-level requester/arbitration model.
module tb_uart_tx_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rq_req, rq_last, rq_ack, grant;
  logic [7:0] rq_data0, rq_data1, tx_data;
  logic       tx_ready, baud_x1, tx_strobe, busy, timeout_err;

  always #5 clk = ~clk;

  uart_tx_sched #(.TIMEOUT_W(4), .MAX_BYTES(32)) dut (
    .clk(clk), .reset(reset), .rq_req(rq_req), .rq_data0(rq_data0), .rq_data1(rq_data1),
    .rq_last(rq_last), .rq_ack(rq_ack), .grant(grant), .tx_ready(tx_ready), .baud_x1(baud_x1),
    .tx_data(tx_data), .tx_strobe(tx_strobe), .busy(busy), .timeout_err(timeout_err)
  );

  int n_tests = 0, n_fail = 0;
  int cyc = 0, n_str, n_str_all, n_to, to_lat, rise_cyc, last_served, cur_own;
  int baud_cnt, mode_ready;
  bit rand_req, rand_baud, released;
  int seq[2], len[2], drop_after[2], tot[2];
  bit want[2], rpt[2];
  logic [1:0] p_req, p_last, prev_grant;
  logic       p_baud, p_ready;
  logic [1:0] glog[$];

  typedef struct {
    logic [1:0] who;
    int         len;
    int         drop;
    bit         stuck;
    int         exp_str;
    int         exp_to;
  } vec_t;
  vec_t tab[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] onehot(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  // Byte stream of requester i: 0x31, 0x32, ... (requester 1 offset by 0x40).
  function automatic logic [7:0] byte_of(input int i);
    return 8'(49 + 64 * i + tot[i]);
  endfunction

  task automatic start_msg(input int i, input int l, input int d);
    want[i] = 1'b1; len[i] = l; drop_after[i] = d; seq[i] = 0;
  endtask

  task automatic rand_msg(input int i);
    int l, d;
    l = ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(1, 6));
    d = -1;
    if (l >= 2 && $urandom_range(0, 4) == 0) d = int'($urandom_range(1, (l > 5) ? 4 : l - 1));
    start_msg(i, l, d);
  endtask

  task automatic track_reset();
    cur_own = -1; last_served = 1; prev_grant = 2'b00; n_str = 0; released = 1'b0;
    glog.delete();
    for (int i = 0; i < 2; i++) begin
      seq[i] = 0; tot[i] = 0; want[i] = 1'b0; len[i] = 1; drop_after[i] = -1; rpt[i] = 1'b0;
    end
  endtask

  task automatic drive();
    logic [1:0] lst;
    for (int i = 0; i < 2; i++) lst[i] = want[i] && len[i] > 0 && seq[i] == len[i] - 1;
    rq_req   = {want[1], want[0]};
    rq_last  = lst;
    rq_data0 = byte_of(0);
    rq_data1 = byte_of(1);
    baud_x1  = (baud_cnt == 0);
    if (baud_cnt == 0) baud_cnt = rand_baud ? int'($urandom_range(1, 4)) : 3;
    else baud_cnt--;
    tx_ready = (mode_ready == 0) ? ($urandom_range(0, 7) != 0) : (mode_ready == 1);
    p_req = rq_req; p_last = rq_last; p_baud = baud_x1; p_ready = tx_ready;
  endtask

  // Sample on the falling edge, check against the model, then advance the requesters.
  task automatic step();
    logic [1:0] exp_g;
    int         acked;
    bit         fin;
    @(negedge clk);
    cyc++;
    acked = -1;
    if (grant != 2'b00 && prev_grant == 2'b00 && cur_own < 0) begin
      exp_g = (p_req == 2'b11) ? ((last_served == 1) ? 2'b01 : 2'b10) : p_req;
      chk("arb_grant", 32'(grant), 32'(exp_g));
      cur_own = grant[1] ? 1 : 0; n_str = 0; rise_cyc = cyc; glog.push_back(grant);
    end
    if (tx_strobe) begin
      if (cur_own < 0) begin
        chk("strobe_without_grant", 32'(tx_strobe), 32'(0));
      end else begin
        fin = p_last[cur_own] || (n_str + 1 == 32);
        chk("strobe_cond", 32'({p_baud, p_ready, p_req[cur_own]}), 32'(3'b111));
        chk("tx_data", 32'(tx_data), 32'(byte_of(cur_own)));
        chk("rq_ack", 32'(rq_ack), 32'(onehot(cur_own)));
        chk("grant_after_strobe", 32'(grant), fin ? 32'(0) : 32'(onehot(cur_own)));
        acked = cur_own; n_str++; n_str_all++; seq[cur_own]++; tot[cur_own]++;
      end
    end else begin
      chk("rq_ack_quiet", 32'(rq_ack), 32'(0));
      if (cur_own >= 0 && !p_req[cur_own] && n_str > 0) chk("drop_release", 32'(grant), 32'(0));
    end
    if (cur_own >= 0 && grant == 2'b00) begin
      last_served = cur_own; cur_own = -1; released = 1'b1;
    end
    if (timeout_err) begin n_to++; to_lat = cyc - rise_cyc; end
    prev_grant = grant;
    for (int i = 0; i < 2; i++) begin
      if (acked == i) begin
        if (len[i] > 0 && seq[i] == len[i]) begin
          if (rpt[i]) start_msg(i, len[i], -1);
          else begin want[i] = 1'b0; seq[i] = 0; end
        end else if (drop_after[i] == seq[i]) begin
          want[i] = 1'b0; drop_after[i] = -1; seq[i] = 0;
        end
      end else if (!want[i] && rand_req && $urandom_range(0, 3) == 0) begin
        rand_msg(i);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    track_reset();
    rand_req = 1'b0; rand_baud = 1'b0; mode_ready = 1; baud_cnt = 0;
    n_to = 0; n_str_all = 0; to_lat = -1;
    drive();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_to_release(input int bound, input bit stop_after);
    bit done;
    done = 1'b0;
    released = 1'b0;
    for (int k = 0; k < bound && !done; k++) begin
      step();
      if (released) begin
        done = 1'b1;
        if (stop_after) begin want[0] = 1'b0; want[1] = 1'b0; end
      end
      drive();
    end
    chk("release_within_bound", 32'(done), 32'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    tab[0] = '{who: 2'b01, len: 2, drop: -1, stuck: 1'b0, exp_str: 2, exp_to: 0};
    tab[1] = '{who: 2'b10, len: 3, drop:  1, stuck: 1'b0, exp_str: 1, exp_to: 0};
    tab[2] = '{who: 2'b01, len: 2, drop: -1, stuck: 1'b1, exp_str: 0, exp_to: 1};
    tab[3] = '{who: 2'b10, len: 1, drop: -1, stuck: 1'b0, exp_str: 1, exp_to: 0};
    tab[4] = '{who: 2'b10, len: 5, drop: -1, stuck: 1'b0, exp_str: 5, exp_to: 0};
    tab[5] = '{who: 2'b01, len: 4, drop:  2, stuck: 1'b0, exp_str: 2, exp_to: 0};

    // Reset state
    do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({grant, rq_ack, tx_strobe, tx_data, busy, timeout_err}), 32'(0));

    // Directed single-message vectors
    for (int e = 0; e < 6; e++) begin
      do_reset();
      mode_ready = tab[e].stuck ? 2 : 1;
      for (int i = 0; i < 2; i++) if (tab[e].who[i]) start_msg(i, tab[e].len, tab[e].drop);
      drive();
      run_to_release(300, 1'b1);
      repeat (2) begin step(); drive(); end
      chk($sformatf("vec%0d_strobes", e), 32'(n_str_all), 32'(tab[e].exp_str));
      chk($sformatf("vec%0d_timeouts", e), 32'(n_to), 32'(tab[e].exp_to));
      chk($sformatf("vec%0d_idle", e), 32'({grant, busy}), 32'(0));
      if (tab[e].exp_to != 0) chk($sformatf("vec%0d_timeout_latency", e), 32'(to_lat), 32'(16));
    end

    // Both requesting one-byte messages continuously: strict alternation from requester 0
    do_reset();
    start_msg(0, 1, -1); start_msg(1, 1, -1); rpt[0] = 1'b1; rpt[1] = 1'b1;
    drive();
    for (int k = 0; k < 300 && glog.size() < 4; k++) begin step(); drive(); end
    chk("rr_grant_count", 32'(glog.size()), 32'(4));
    for (int j = 0; j < 4 && j < glog.size(); j++)
      chk($sformatf("rr_order%0d", j), 32'(glog[j]), (j % 2 == 0) ? 32'(2'b01) : 32'(2'b10));

    // Message with no last flag: forced release after 32 bytes, then re-arbitration
    do_reset();
    start_msg(0, 0, -1);
    drive();
    run_to_release(400, 1'b0);
    chk("cap_strobes", 32'(n_str_all), 32'(32));
    for (int k = 0; k < 8 && glog.size() < 2; k++) begin step(); drive(); end
    chk("cap_regrant_count", 32'(glog.size()), 32'(2));
    if (glog.size() == 2) chk("cap_regrant_owner", 32'(glog[1]), 32'(2'b01));

    // Reset between the first and second byte of a message
    do_reset();
    start_msg(0, 3, -1);
    drive();
    for (int k = 0; k < 100 && n_str_all < 1; k++) begin step(); drive(); end
    chk("pre_reset_first_strobe", 32'(n_str_all), 32'(1));
    step(); drive();
    reset = 1'b1;
    #1;
    chk("reset_async", 32'({grant, rq_ack, tx_strobe, tx_data, busy, timeout_err}), 32'(0));
    repeat (2) @(negedge clk);
    track_reset();
    reset = 1'b0;
    n_str_all = 0;
    start_msg(0, 3, -1);
    drive();
    run_to_release(200, 1'b1);
    chk("post_reset_strobes", 32'(n_str_all), 32'(3));
    chk("post_reset_grants", 32'(glog.size()), 32'(1));

    // Randomized traffic against the model, then drain
    do_reset();
    rand_req = 1'b1; rand_baud = 1'b1; mode_ready = 0;
    drive();
    repeat (3000) begin step(); drive(); end
    rand_req = 1'b0;
    begin
      bit idle;
      idle = 1'b0;
      for (int k = 0; k < 600 && !idle; k++) begin
        step(); drive();
        idle = !want[0] && !want[1] && cur_own < 0 && grant == 2'b00;
      end
      chk("random_drain", 32'(idle), 32'(1));
    end
    repeat (3) begin step(); drive(); end
    chk("random_final_busy", 32'(busy), 32'(0));
    chk("random_no_timeout", 32'(n_to), 32'(0));
    chk("random_activity", 32'(n_str_all > 100), 32'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
